// File: rtl/tdm_pkg.sv
// Shared definitions for the two-channel TDM link (transmitter and receiver).
package tdm_pkg;

  localparam int unsigned TDM_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_shift_reg.sv
// Left-shifting W-bit register with synchronous clear and shift enable.
module tdm_shift_reg
  import tdm_pkg::*;
#(
  parameter int unsigned W = TDM_W
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         bit_in,
  output logic [W-1:0] q
);

  logic [W-1:0] base;

  // clr together with en loads bit_in into an otherwise cleared word
  always_comb begin
    base = clr ? '0 : q;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      q <= (base << 1) | W'(bit_in);
    end else if (clr) begin
      q <= '0;
    end
  end

endmodule

// File: rtl/tdm_demux2.sv
// Two-channel TDM receiver: splits an A/B interleaved serial stream into W-bit words.
module tdm_demux2
  import tdm_pkg::*;
#(
  parameter int unsigned W = TDM_W
) (
  input  logic         CLOCK_50,
  input  logic         Reset,
  input  logic         serial_in,
  input  logic         bit_valid,
  input  logic         frame_start,
  output logic [W-1:0] ch_a,
  output logic [W-1:0] ch_b,
  output logic         out_valid,
  output logic         frame_err,
  output logic         busy
);

  localparam int unsigned IW = $clog2(2 * W);
  localparam logic [IW-1:0] LAST = IW'(2 * W - 1);

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_next;
  logic          shift_a;
  logic          shift_b;
  logic          start;
  logic          restart;
  logic          done;
  logic          clr;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;

  always_comb begin
    state_next = state;
    idx_next   = idx;
    shift_a    = 1'b0;
    shift_b    = 1'b0;
    start      = 1'b0;
    restart    = 1'b0;
    done       = 1'b0;
    if (bit_valid) begin
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            start      = 1'b1;
            shift_a    = 1'b1;
            idx_next   = IW'(1);
            state_next = RECV;
          end
        end
        RECV: begin
          if (frame_start) begin
            start    = 1'b1;
            restart  = 1'b1;
            shift_a  = 1'b1;
            idx_next = IW'(1);
          end else begin
            shift_a = ~idx[0];
            shift_b = idx[0];
            if (idx == LAST) begin
              done       = 1'b1;
              idx_next   = '0;
              state_next = IDLE;
            end else begin
              idx_next = idx + IW'(1);
            end
          end
        end
        default: begin
          state_next = IDLE;
          idx_next   = '0;
        end
      endcase
    end
  end

  assign clr = Reset | start;

  tdm_shift_reg #(.W(W)) u_shift_a (
    .clk    (CLOCK_50),
    .clr    (clr),
    .en     (shift_a & ~Reset),
    .bit_in (serial_in),
    .q      (a_q)
  );

  tdm_shift_reg #(.W(W)) u_shift_b (
    .clk    (CLOCK_50),
    .clr    (clr),
    .en     (shift_b & ~Reset),
    .bit_in (serial_in),
    .q      (b_q)
  );

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state     <= IDLE;
      idx       <= '0;
      ch_a      <= '0;
      ch_b      <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      out_valid <= done;
      frame_err <= restart;
      // B LSB arrives this cycle, so it is merged here rather than read back from u_shift_b
      if (done) begin
        ch_a <= a_q;
        ch_b <= (b_q << 1) | W'(serial_in);
      end
    end
  end

  assign busy = (state == RECV);

endmodule

// File: tb/tb_tdm_demux2.sv
// Self-checking bench for tdm_demux2: fixed vector table, directed sequences and random traffic.
module tb_tdm_demux2;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sin = 1'b0;
  logic         bv  = 1'b0;
  logic         fs  = 1'b0;
  logic [W-1:0] ch_a;
  logic [W-1:0] ch_b;
  logic         out_valid;
  logic         frame_err;
  logic         busy;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  tdm_demux2 #(.W(W)) dut (
    .CLOCK_50    (clk),
    .Reset       (rst),
    .serial_in   (sin),
    .bit_valid   (bv),
    .frame_start (fs),
    .ch_a        (ch_a),
    .ch_b        (ch_b),
    .out_valid   (out_valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  // Reference model: collects the frame's bits in a queue and de-interleaves on completion.
  int           bits[$];
  logic         m_in_frame = 1'b0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic         m_ov = 1'b0;
  logic         m_err = 1'b0;

  task automatic model_step();
    int a, b;
    if (rst) begin
      m_in_frame = 1'b0;
      bits.delete();
      m_a = '0; m_b = '0; m_ov = 1'b0; m_err = 1'b0;
      return;
    end
    m_ov = 1'b0;
    m_err = 1'b0;
    if (bv) begin
      if (fs) begin
        if (m_in_frame) m_err = 1'b1;
        bits.delete();
        bits.push_back(int'(sin));
        m_in_frame = 1'b1;
      end else if (m_in_frame) begin
        bits.push_back(int'(sin));
        if (bits.size() == 2 * W) begin
          a = 0; b = 0;
          for (int i = 0; i < 2 * W; i++) begin
            if (i % 2 == 0) a = a * 2 + bits[i];
            else            b = b * 2 + bits[i];
          end
          m_a = W'(a);
          m_b = W'(b);
          m_ov = 1'b1;
          m_in_frame = 1'b0;
          bits.delete();
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    check("ch_a", 32'(ch_a), 32'(m_a));
    check("ch_b", 32'(ch_b), 32'(m_b));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("frame_err", 32'(frame_err), 32'(m_err));
    check("busy", 32'(busy), 32'(m_in_frame));
  endtask

  task automatic cyc(input logic r, input logic v, input logic f, input logic s);
    rst = r; bv = v; fs = f; sin = s;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  // Sends one full frame; 3 idle cycles are inserted after bit g1 and bit g2 (0 = none).
  task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                            input int g1, input int g2);
    logic s;
    for (int k = 0; k < 2 * W; k++) begin
      s = (k % 2 == 0) ? a[W-1-k/2] : b[W-1-k/2];
      cyc(1'b0, 1'b1, (k == 0), s);
      if (k + 1 == g1 || k + 1 == g2)
        for (int g = 0; g < 3; g++) cyc(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  typedef struct {
    logic         r, v, f, s;
    logic [W-1:0] ea, eb;
    logic         eov, eerr, ebusy;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // Basic frame 1,0,0,1,1,1,0,0 -> A=1010, B=0110
    tbl[0] = '{1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0};
    tbl[1] = '{0, 1, 1, 1, 4'b0000, 4'b0000, 0, 0, 1};
    tbl[2] = '{0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 1};
    tbl[3] = '{0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 1};
    tbl[4] = '{0, 1, 0, 1, 4'b0000, 4'b0000, 0, 0, 1};
    tbl[5] = '{0, 1, 0, 1, 4'b0000, 4'b0000, 0, 0, 1};
    tbl[6] = '{0, 1, 0, 1, 4'b0000, 4'b0000, 0, 0, 1};
    tbl[7] = '{0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 1};
    tbl[8] = '{0, 1, 0, 0, 4'b1010, 4'b0110, 1, 0, 0};
    tbl[9] = '{0, 0, 0, 1, 4'b1010, 4'b0110, 0, 0, 0};

    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].r; bv = tbl[i].v; fs = tbl[i].f; sin = tbl[i].s;
      @(posedge clk);
      model_step();
      #1;
      check("tbl_ch_a", 32'(ch_a), 32'(tbl[i].ea));
      check("tbl_ch_b", 32'(ch_b), 32'(tbl[i].eb));
      check("tbl_out_valid", 32'(out_valid), 32'(tbl[i].eov));
      check("tbl_frame_err", 32'(frame_err), 32'(tbl[i].eerr));
      check("tbl_busy", 32'(busy), 32'(tbl[i].ebusy));
    end

    // Gapped frame
    send_frame(4'b1010, 4'b0110, 2, 5);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Early restart on bit 4, then a clean frame
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(4'b1111, 4'b0000, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Restart exactly on the last-bit cycle
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 2 * W - 2; k++) cyc(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
    send_frame(4'b0110, 4'b1001, 0, 0);

    // Back-to-back frames, second start on the out_valid cycle
    send_frame(4'b0011, 4'b1100, 0, 0);
    send_frame(4'b0101, 4'b1010, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-frame
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 1'b0, 1'(k));
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    send_frame(4'b1001, 4'b0110, 0, 0);

    // Idle noise without frame_start
    for (int k = 0; k < 20; k++) cyc(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));

    // Random traffic
    for (int k = 0; k < 3000; k++)
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
